// File: rtl/cache_controller.sv
// ---------------------------------------------------------------------------
// cache_controller
//   Sequencing FSM for a 64-line direct-mapped write-back data cache. It sits
//   between the CPU load/store port, the cache array and main memory. Hits
//   finish in COMPARE. A miss optionally writes back a dirty victim, refills
//   the line from memory and then re-compares, which is then a guaranteed hit.
//   Every cache-array control is driven on every cycle, because the array
//   rewrites valid/dirty every clock.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cpu_*_i / cpu_*_o   CPU request (req/we/addr/wdata) and response
//                       (busy/done/rdata)
//   cache_*             cache array address/data/strobes and status inputs
//                       (hit, line valid, dirty, victim tag, read data)
//   mem_*               memory request/ack handshake with address and data
//   hit_count_o,
//   miss_count_o        access statistics, present only with CACHE_STATS_EN
//
// Optional feature macro: CACHE_STATS_EN
// ---------------------------------------------------------------------------
module cache_controller #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req_i,
  input  logic             cpu_we_i,
  input  logic [31:0]      cpu_addr_i,
  input  logic [31:0]      cpu_wdata_i,
  output logic             cpu_busy_o,
  output logic             cpu_done_o,
  output logic [31:0]      cpu_rdata_o,
  output logic [31:0]      cache_addr_o,
  output logic [31:0]      cache_wdata_o,
  output logic             we_cache_o,
  output logic             set_valid_o,
  output logic             set_dirty_o,
  output logic             tag_we_o,
  input  logic             cache_hit_i,
  input  logic             line_valid_i,
  input  logic             cache_dirty_i,
  input  logic [TAG_W-1:0] victim_tag_i,
  input  logic [31:0]      cache_rdata_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i,
  input  logic             mem_ack_i
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]      hit_count_o,
  output logic [31:0]      miss_count_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  // Marks the COMPARE that follows a refill, so it is not counted as an access.
  logic        refill_q, refill_d;
  logic        capture;

  assign capture = (state_q == IDLE) && cpu_req_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      refill_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      refill_q <= refill_d;
      if (capture) begin
        addr_q  <= cpu_addr_i;
        we_q    <= cpu_we_i;
        wdata_q <= cpu_wdata_i;
      end
    end
  end

  // Next state and all outputs; the hold values keep the line's valid/dirty
  // bits unchanged on cycles that do not deliberately modify them.
  always_comb begin
    state_d       = state_q;
    rdata_d       = rdata_q;
    done_d        = 1'b0;
    refill_d      = refill_q;
    cpu_busy_o    = (state_q != IDLE);
    cache_addr_o  = (state_q == IDLE) ? cpu_addr_i : addr_q;
    cache_wdata_o = '0;
    we_cache_o    = 1'b0;
    tag_we_o      = 1'b0;
    set_valid_o   = line_valid_i;
    set_dirty_o   = cache_dirty_i;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;

    unique case (state_q)
      IDLE: begin
        refill_d = 1'b0;
        if (cpu_req_i) state_d = COMPARE;
      end
      COMPARE: begin
        refill_d = 1'b0;
        if (cache_hit_i) begin
          done_d  = 1'b1;
          state_d = IDLE;
          if (we_q) begin
            we_cache_o    = 1'b1;
            cache_wdata_o = wdata_q;
            set_valid_o   = 1'b1;
            set_dirty_o   = 1'b1;
          end else begin
            rdata_d = cache_rdata_i;
          end
        end else if (cache_dirty_i && line_valid_i) begin
          state_d = WRITEBACK;
        end else begin
          // An invalid line may carry a stale dirty bit; it is never written back.
          state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {{(32-TAG_W-INDEX_W){1'b0}}, victim_tag_i, addr_q[INDEX_W-1:0]};
        mem_wdata_o = cache_rdata_i;
        if (mem_ack_i) begin
          set_dirty_o = 1'b0;
          state_d     = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = addr_q;
        if (mem_ack_i) begin
          we_cache_o    = 1'b1;
          cache_wdata_o = mem_rdata_i;
          tag_we_o      = 1'b1;
          set_valid_o   = 1'b1;
          set_dirty_o   = 1'b0;
          refill_d      = 1'b1;
          state_d       = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase

    // While reset is held every output is forced low, including the
    // pass-through paths that do not depend on state.
    if (!rst_n) begin
      cpu_busy_o    = 1'b0;
      cache_addr_o  = '0;
      cache_wdata_o = '0;
      we_cache_o    = 1'b0;
      tag_we_o      = 1'b0;
      set_valid_o   = 1'b0;
      set_dirty_o   = 1'b0;
      mem_req_o     = 1'b0;
      mem_we_o      = 1'b0;
      mem_addr_o    = '0;
      mem_wdata_o   = '0;
    end
  end

  assign cpu_done_o  = done_q;
  assign cpu_rdata_o = rdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  // One count per access; the re-compare after a refill is skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (state_q == COMPARE && !refill_q) begin
      if (cache_hit_i) hit_count_q  <= hit_count_q + 32'd1;
      else             miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count_o  = hit_count_q;
  assign miss_count_o = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// ---------------------------------------------------------------------------
// tb_cache_controller
//   Directed bench for cache_controller. The cache array and memory are
//   played by hand-driven inputs; every expected value is written out below.
// ---------------------------------------------------------------------------
module tb_cache_controller;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_busy, cpu_done;
  logic [31:0] cpu_rdata;
  logic [31:0] cache_addr, cache_wdata;
  logic        we_cache, set_valid, set_dirty, tag_we;
  logic        cache_hit, line_valid, cache_dirty;
  logic [9:0]  victim_tag;
  logic [31:0] cache_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int total = 0;
  int bad   = 0;

  cache_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_busy_o   (cpu_busy),
    .cpu_done_o   (cpu_done),
    .cpu_rdata_o  (cpu_rdata),
    .cache_addr_o (cache_addr),
    .cache_wdata_o(cache_wdata),
    .we_cache_o   (we_cache),
    .set_valid_o  (set_valid),
    .set_dirty_o  (set_dirty),
    .tag_we_o     (tag_we),
    .cache_hit_i  (cache_hit),
    .line_valid_i (line_valid),
    .cache_dirty_i(cache_dirty),
    .victim_tag_i (victim_tag),
    .cache_rdata_i(cache_rdata),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .mem_ack_i    (mem_ack)
`ifdef CACHE_STATS_EN
    ,
    .hit_count_o  (hit_count),
    .miss_count_o (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    cpu_req   = req;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  task automatic setLine(input logic hit, input logic valid, input logic dirty,
                         input logic [9:0] tag, input logic [31:0] data);
    cache_hit   = hit;
    line_valid  = valid;
    cache_dirty = dirty;
    victim_tag  = tag;
    cache_rdata = data;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    applyStimulus(1'b0, 1'b0, 32'h45, 32'h0);
    setLine(1'b0, 1'b1, 1'b1, 10'd0, 32'h0);
    #2;
    checkOutput("rst_busy", {31'b0, cpu_busy}, 32'd0);
    checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_cache_addr", cache_addr, 32'h0);
    checkOutput("rst_set_valid", {31'b0, set_valid}, 32'd0);
    checkOutput("rst_done", {31'b0, cpu_done}, 32'd0);
    checkOutput("rst_rdata", cpu_rdata, 32'h0);

    // Scenario 1: load 0x45 into an empty line -> ALLOCATE, one wait cycle.
    tick;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h45, 32'h0);
    setLine(1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
    #1;
    checkOutput("s1_idle_cache_addr", cache_addr, 32'h45);
    checkOutput("s1_idle_busy", {31'b0, cpu_busy}, 32'd0);
    tick;
    applyStimulus(1'b0, 1'b0, 32'h99, 32'h0);
    #1;
    checkOutput("s1_cmp_busy", {31'b0, cpu_busy}, 32'd1);
    checkOutput("s1_cmp_latched_addr", cache_addr, 32'h45);
    checkOutput("s1_cmp_mem_req", {31'b0, mem_req}, 32'd0);
    tick;
    checkOutput("s1_alloc_mem_req", {31'b0, mem_req}, 32'd1);
    checkOutput("s1_alloc_mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("s1_alloc_mem_addr", mem_addr, 32'h45);
    checkOutput("s1_alloc_we_cache", {31'b0, we_cache}, 32'd0);
    tick;
    checkOutput("s1_wait_mem_req", {31'b0, mem_req}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #1;
    checkOutput("s1_ack_we_cache", {31'b0, we_cache}, 32'd1);
    checkOutput("s1_ack_cache_wdata", cache_wdata, 32'hDEADBEEF);
    checkOutput("s1_ack_tag_we", {31'b0, tag_we}, 32'd1);
    checkOutput("s1_ack_set_valid", {31'b0, set_valid}, 32'd1);
    checkOutput("s1_ack_set_dirty", {31'b0, set_dirty}, 32'd0);
    tick;
    mem_ack = 1'b0;
    setLine(1'b1, 1'b1, 1'b0, 10'd1, 32'hDEADBEEF);
    #1;
    checkOutput("s1_recmp_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("s1_recmp_we_cache", {31'b0, we_cache}, 32'd0);
    checkOutput("s1_recmp_done", {31'b0, cpu_done}, 32'd0);
    tick;
    checkOutput("s1_done", {31'b0, cpu_done}, 32'd1);
    checkOutput("s1_rdata", cpu_rdata, 32'hDEADBEEF);
    checkOutput("s1_done_busy", {31'b0, cpu_busy}, 32'd0);

    // Scenario 2: back-to-back load hit of 0x45, issued in the done cycle.
    applyStimulus(1'b1, 1'b0, 32'h45, 32'h0);
    #1;
    checkOutput("s2_idle_cache_addr", cache_addr, 32'h45);
    tick;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("s2_cmp_busy", {31'b0, cpu_busy}, 32'd1);
    checkOutput("s2_cmp_done", {31'b0, cpu_done}, 32'd0);
    checkOutput("s2_cmp_mem_req", {31'b0, mem_req}, 32'd0);
    tick;
    checkOutput("s2_done", {31'b0, cpu_done}, 32'd1);
    checkOutput("s2_rdata", cpu_rdata, 32'hDEADBEEF);

    // Scenario 3: store hit to 0x45, with a stray mem_ack and a request while busy.
    applyStimulus(1'b1, 1'b1, 32'h45, 32'h12345678);
    mem_ack = 1'b1;
    #1;
    checkOutput("s3_stray_ack_mem_req", {31'b0, mem_req}, 32'd0);
    tick;
    applyStimulus(1'b1, 1'b0, 32'h77, 32'h0);
    #1;
    checkOutput("s3_cmp_we_cache", {31'b0, we_cache}, 32'd1);
    checkOutput("s3_cmp_cache_wdata", cache_wdata, 32'h12345678);
    checkOutput("s3_cmp_set_valid", {31'b0, set_valid}, 32'd1);
    checkOutput("s3_cmp_set_dirty", {31'b0, set_dirty}, 32'd1);
    checkOutput("s3_cmp_tag_we", {31'b0, tag_we}, 32'd0);
    checkOutput("s3_cmp_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("s3_cmp_cache_addr", cache_addr, 32'h45);
    tick;
    checkOutput("s3_done", {31'b0, cpu_done}, 32'd1);
    checkOutput("s3_rdata_held", cpu_rdata, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    mem_ack = 1'b0;
    tick;
    checkOutput("s3_no_queue_busy", {31'b0, cpu_busy}, 32'd0);
    checkOutput("s3_no_queue_done", {31'b0, cpu_done}, 32'd0);

    // Scenario 4: load 0x85 hits dirty line 5 (tag 1) -> writeback then refill.
    setLine(1'b0, 1'b1, 1'b1, 10'd1, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 32'h85, 32'h0);
    tick;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("s4_cmp_busy", {31'b0, cpu_busy}, 32'd1);
    tick;
    checkOutput("s4_wb_mem_req", {31'b0, mem_req}, 32'd1);
    checkOutput("s4_wb_mem_we", {31'b0, mem_we}, 32'd1);
    checkOutput("s4_wb_mem_addr", mem_addr, 32'h45);
    checkOutput("s4_wb_mem_wdata", mem_wdata, 32'h12345678);
    checkOutput("s4_wb_cache_addr", cache_addr, 32'h85);
    mem_ack = 1'b1;
    #1;
    checkOutput("s4_wb_ack_set_dirty", {31'b0, set_dirty}, 32'd0);
    checkOutput("s4_wb_ack_set_valid", {31'b0, set_valid}, 32'd1);
    checkOutput("s4_wb_ack_we_cache", {31'b0, we_cache}, 32'd0);
    tick;
    mem_ack = 1'b0;
    cache_dirty = 1'b0;
    #1;
    checkOutput("s4_alloc_mem_req", {31'b0, mem_req}, 32'd1);
    checkOutput("s4_alloc_mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("s4_alloc_mem_addr", mem_addr, 32'h85);
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    #1;
    checkOutput("s4_alloc_cache_wdata", cache_wdata, 32'hCAFEF00D);
    checkOutput("s4_alloc_tag_we", {31'b0, tag_we}, 32'd1);
    tick;
    mem_ack = 1'b0;
    setLine(1'b1, 1'b1, 1'b0, 10'd2, 32'hCAFEF00D);
    tick;
    checkOutput("s4_done", {31'b0, cpu_done}, 32'd1);
    checkOutput("s4_rdata", cpu_rdata, 32'hCAFEF00D);
`ifdef CACHE_STATS_EN
    checkOutput("stats_hit_count", hit_count, 32'd2);
    checkOutput("stats_miss_count", miss_count, 32'd2);
`endif

    // Scenario 5: invalid line with stale dirty bit -> ALLOCATE; reset mid-refill.
    setLine(1'b0, 1'b0, 1'b1, 10'd3, 32'h0BADF00D);
    applyStimulus(1'b1, 1'b0, 32'h1C3, 32'h0);
    tick;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick;
    checkOutput("s5_alloc_mem_req", {31'b0, mem_req}, 32'd1);
    checkOutput("s5_alloc_mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("s5_alloc_mem_addr", mem_addr, 32'h1C3);
    rst_n = 1'b0;
    #1;
    checkOutput("s5_rst_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("s5_rst_busy", {31'b0, cpu_busy}, 32'd0);
    tick;
    rst_n = 1'b1;
`ifdef CACHE_STATS_EN
    checkOutput("stats_rst_hit_count", hit_count, 32'd0);
    checkOutput("stats_rst_miss_count", miss_count, 32'd0);
`endif
    setLine(1'b1, 1'b1, 1'b0, 10'd1, 32'h55AA55AA);
    applyStimulus(1'b1, 1'b0, 32'h45, 32'h0);
    #1;
    checkOutput("s5_post_idle_busy", {31'b0, cpu_busy}, 32'd0);
    tick;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("s5_post_cmp_busy", {31'b0, cpu_busy}, 32'd1);
    checkOutput("s5_post_cmp_cache_addr", cache_addr, 32'h45);
    tick;
    checkOutput("s5_post_done", {31'b0, cpu_done}, 32'd1);
    checkOutput("s5_post_rdata", cpu_rdata, 32'h55AA55AA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
